// File: rtl/scalar_wb_queue.sv
// Writeback merge queue for the 8x16 scalar register file: mem and ALU requests enter an
// in-order FIFO, retire one per cycle to the write port, and a per-register count drives RAW stalls.
module scalar_wb_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_dst,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              busy_1,
    output logic              busy_2
);

    localparam int NREG = 1 << ADDR_W;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int SW   = $clog2(DEPTH + 2);

    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    // Handshake: a request is taken at the rising edge where valid & ready are both high;
    // ready depends only on the start-of-cycle count (and mem_valid for the ALU side).
    logic [ADDR_W-1:0] fifo_dst  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     pend_cnt  [NREG];

    logic              mem_acc;
    logic              alu_acc;
    logic              deq;
    logic [PW-1:0]     alu_slot;
    logic [PW-1:0]     wr_ptr_next;
    logic [CW:0]       count_sum;
    logic [SW:0]       pend_sum  [NREG];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign mem_ready = (count <= DEPTH_M1);
    assign alu_ready = (count <= DEPTH_M2) | ((count == DEPTH_M1) & ~mem_valid);

    assign mem_acc = mem_valid & mem_ready;
    assign alu_acc = alu_valid & alu_ready;
    assign deq     = (count != '0);

    // mem always takes the first free slot, so the ALU entry lands behind it
    assign alu_slot = mem_acc ? ptr_inc(wr_ptr) : wr_ptr;

    always_comb begin
        wr_ptr_next = wr_ptr;
        if (mem_acc && alu_acc) begin
            wr_ptr_next = ptr_inc(ptr_inc(wr_ptr));
        end else if (mem_acc || alu_acc) begin
            wr_ptr_next = ptr_inc(wr_ptr);
        end
    end

    assign count_sum = {1'b0, count} + (CW+1)'(mem_acc) + (CW+1)'(alu_acc) - (CW+1)'(deq);

    // Pending writes per register: entries in the FIFO plus the one on the write port.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_sum[r] = {1'b0, pend_cnt[r]}
                        + (SW+1)'(mem_acc && (mem_dst == ADDR_W'(r)))
                        + (SW+1)'(alu_acc && (alu_dst == ADDR_W'(r)))
                        - (SW+1)'(wr_en && (wr_dst == ADDR_W'(r)));
        end
    end

    assign busy_1 = (pend_cnt[rd_addr_1] != '0);
    assign busy_2 = (pend_cnt[rd_addr_2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
            for (int r = 0; r < NREG; r++) begin
                pend_cnt[r] <= '0;
            end
        end else begin
            if (mem_acc) begin
                fifo_dst[wr_ptr]  <= mem_dst;
                fifo_data[wr_ptr] <= mem_data;
            end
            if (alu_acc) begin
                fifo_dst[alu_slot]  <= alu_dst;
                fifo_data[alu_slot] <= alu_data;
            end
            wr_ptr <= wr_ptr_next;

            wr_en <= deq;
            if (deq) begin
                wr_dst  <= fifo_dst[rd_ptr];
                wr_data <= fifo_data[rd_ptr];
                rd_ptr  <= ptr_inc(rd_ptr);
            end

            // wraps to a huge value on underflow, so one bound catches both directions
            assert (count_sum <= (CW+1)'(DEPTH));
            count <= count_sum[CW-1:0];

            for (int r = 0; r < NREG; r++) begin
                assert (pend_sum[r] <= (SW+1)'(DEPTH + 1));
                pend_cnt[r] <= pend_sum[r][SW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_scalar_wb_queue.sv
// Bench for scalar_wb_queue: directed scenarios then random traffic, checked every cycle
// against a queue-based reference of the writeback stream.
module tb_scalar_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [2:0]  mem_dst;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [2:0]  alu_dst;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        wr_en;
    logic [2:0]  wr_dst;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_1;
    logic [2:0]  rd_addr_2;
    logic        busy_1;
    logic        busy_2;

    int errors = 0;
    int checks = 0;

    // reference: queued {dst,data} entries and the write-port contents
    logic [18:0] exp_q[$];
    logic        m_en;
    logic [2:0]  m_dst;
    logic [15:0] m_data;
    bit          mem_took;
    bit          alu_took;

    // register file written by the DUT's write port
    logic [15:0] rf [8] = '{default: 16'h0};

    scalar_wb_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .busy_1(busy_1), .busy_2(busy_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) rf[wr_dst] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_mem_ready();
        return exp_q.size() <= DEPTH - 1;
    endfunction

    function automatic bit exp_alu_ready();
        return (exp_q.size() <= DEPTH - 2) || ((exp_q.size() == DEPTH - 1) && !mem_valid);
    endfunction

    function automatic bit exp_busy(input logic [2:0] r);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][18:16] == r) n++;
        if (m_en && m_dst == r) n++;
        return n != 0;
    endfunction

    task automatic model_edge();
        mem_took = 0;
        alu_took = 0;
        if (rst) begin
            exp_q.delete();
            m_en   = 1'b0;
            m_dst  = 3'd0;
            m_data = 16'h0;
        end else begin
            bit mr = exp_mem_ready();
            bit ar = exp_alu_ready();
            mem_took = mem_valid && mr;
            alu_took = alu_valid && ar;
            if (exp_q.size() > 0) begin
                logic [18:0] h = exp_q.pop_front();
                m_en   = 1'b1;
                m_dst  = h[18:16];
                m_data = h[15:0];
            end else begin
                m_en = 1'b0;
            end
            if (mem_took) exp_q.push_back({mem_dst, mem_data});
            if (alu_took) exp_q.push_back({alu_dst, alu_data});
        end
    endtask

    task automatic check_outputs();
        chk("mem_ready", mem_ready, exp_mem_ready());
        chk("alu_ready", alu_ready, exp_alu_ready());
        chk("busy_1", busy_1, exp_busy(rd_addr_1));
        chk("busy_2", busy_2, exp_busy(rd_addr_2));
        chk("wr_en", wr_en, m_en);
        chk("wr_dst", wr_dst, m_dst);
        chk("wr_data", wr_data, m_data);
    endtask

    // inputs are set just after a falling edge; this checks, crosses one rising edge, and
    // returns just after the next falling edge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic expect_port(input string tag, input logic en, input logic [2:0] dst,
                               input logic [15:0] data);
        #1;
        chk({tag, "_en"}, wr_en, en);
        chk({tag, "_dst"}, wr_dst, dst);
        chk({tag, "_data"}, wr_data, data);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_dst = 0; mem_data = 0;
        alu_valid = 0; alu_dst = 0; alu_data = 0;
        rd_addr_1 = 0; rd_addr_2 = 0;
        m_en = 0; m_dst = 0; m_data = 0;

        // reset held for two cycles
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        rst = 1'b0;
        expect_port("t1_rst", 1'b0, 3'd0, 16'h0);
        chk("t1_mem_ready", mem_ready, 1);
        chk("t1_alu_ready", alu_ready, 1);
        chk("t1_busy_1", busy_1, 0);
        chk("t1_busy_2", busy_2, 0);
        tick();

        // single ALU write R3
        alu_valid = 1; alu_dst = 3'd3; alu_data = 16'h1234; rd_addr_1 = 3'd3;
        tick();
        alu_valid = 0;
        #1;
        chk("t2_busy_n1", busy_1, 1);
        chk("t2_wr_en_n1", wr_en, 0);
        tick();
        expect_port("t2_n2", 1'b1, 3'd3, 16'h1234);
        chk("t2_busy_n2", busy_1, 1);
        tick();
        #1;
        chk("t2_wr_en_n3", wr_en, 0);
        chk("t2_busy_n3", busy_1, 0);
        tick();

        // simultaneous mem R2 and alu R5
        mem_valid = 1; mem_dst = 3'd2; mem_data = 16'hAAAA;
        alu_valid = 1; alu_dst = 3'd5; alu_data = 16'h5555;
        tick();
        mem_valid = 0; alu_valid = 0;
        tick();
        expect_port("t3_n2", 1'b1, 3'd2, 16'hAAAA);
        tick();
        expect_port("t3_n3", 1'b1, 3'd5, 16'h5555);
        tick();
        tick();

        // both producers held valid: queue fills until the ALU side stalls
        mem_valid = 1; mem_dst = 3'd1; mem_data = 16'h4000;
        alu_valid = 1; alu_dst = 3'd6; alu_data = 16'h5000;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i >= 2) begin
                chk("t4_alu_stall", alu_ready, 0);
                chk("t4_mem_ok", mem_ready, 1);
            end
            tick();
            if (mem_took) begin mem_dst = 3'(i); mem_data = 16'h4001 + 16'(i); end
            if (alu_took) begin alu_dst = 3'(7 - i); alu_data = 16'h5001 + 16'(i); end
        end
        mem_valid = 0;
        tick();
        alu_valid = 0;
        repeat (5) tick();

        // same register from both producers
        mem_valid = 1; mem_dst = 3'd4; mem_data = 16'h1111;
        alu_valid = 1; alu_dst = 3'd4; alu_data = 16'h2222; rd_addr_2 = 3'd4;
        tick();
        mem_valid = 0; alu_valid = 0;
        #1 chk("t5_busy_n1", busy_2, 1);
        tick();
        expect_port("t5_n2", 1'b1, 3'd4, 16'h1111);
        chk("t5_busy_n2", busy_2, 1);
        tick();
        expect_port("t5_n3", 1'b1, 3'd4, 16'h2222);
        chk("t5_busy_n3", busy_2, 1);
        tick();
        #1;
        chk("t5_busy_n4", busy_2, 0);
        chk("t5_wr_en_n4", wr_en, 0);
        chk("t5_final_r4", rf[4], 16'h2222);
        tick();

        // reset with three entries in flight
        mem_valid = 1; mem_dst = 3'd1; mem_data = 16'h6661;
        alu_valid = 1; alu_dst = 3'd6; alu_data = 16'h6662; rd_addr_1 = 3'd6;
        tick();
        alu_valid = 0; mem_dst = 3'd7; mem_data = 16'h6663;
        tick();
        mem_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        expect_port("t6_post", 1'b0, 3'd0, 16'h0);
        chk("t6_busy_1", busy_1, 0);
        chk("t6_mem_ready", mem_ready, 1);
        chk("t6_alu_ready", alu_ready, 1);
        tick();
        #1 chk("t6_no_write", wr_en, 0);
        tick();
        alu_valid = 1; alu_dst = 3'd2; alu_data = 16'h7777;
        tick();
        alu_valid = 0;
        tick();
        expect_port("t6_new", 1'b1, 3'd2, 16'h7777);
        tick();
        tick();

        // random traffic with occasional resets; producers hold until accepted
        mem_took = 1; alu_took = 1;
        for (int i = 0; i < 600; i++) begin
            if (mem_took || !mem_valid) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_dst   = 3'($urandom_range(0, 7));
                mem_data  = 16'($urandom);
            end
            if (alu_took || !alu_valid) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_dst   = 3'($urandom_range(0, 7));
                alu_data  = 16'($urandom);
            end
            rd_addr_1 = 3'($urandom_range(0, 7));
            rd_addr_2 = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0; mem_valid = 0; alu_valid = 0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
